// File: rtl/wallace_tree.sv
// Unsigned 16x16 -> 32-bit Wallace-tree multiplier.
// The 16 partial-product rows pass through six carry-save layers (16-11-8-6-4-3-2), then a ripple adder and the output register.
package wallace_tree_pkg;

    // Number of live bits in column c of row group g (rows 3g..3g+2).
    function automatic int col_count(input logic [511:0] m, input int g, input int c);
        int n;
        n = 0;
        for (int r = 0; r < 3; r++) begin
            if (m[(3 * g + r) * 32 + c]) begin
                n = n + 1;
            end else begin
                n = n + 0;
            end
        end
        return n;
    endfunction

    // A column produces a carry when it holds three bits, or two bits plus
    // a carry arriving from below (the carry-row slot is then taken).
    function automatic bit carry_in(input logic [511:0] m, input int g, input int c);
        bit cy;
        int n;
        cy = 1'b0;
        for (int k = 0; k < c; k++) begin
            n  = col_count(m, g, k);
            cy = (n == 3) || ((n == 2) && cy);
        end
        return cy;
    endfunction

    // Row offset (0..2) of the k-th live bit in column c of group g.
    function automatic int pick(input logic [511:0] m, input int g, input int c, input int k);
        int seen;
        int res;
        seen = 0;
        res  = 0;
        for (int r = 0; r < 3; r++) begin
            if (m[(3 * g + r) * 32 + c]) begin
                if (seen == k) begin
                    res = r;
                end else begin
                    res = res;
                end
                seen = seen + 1;
            end else begin
                seen = seen;
            end
        end
        return res;
    endfunction

    function automatic logic [511:0] pp_mask();
        logic [511:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) begin
            m[i * 32 + i +: 16] = 16'hFFFF;
        end
        return m;
    endfunction

    // Live-bit map of the rows leaving one carry-save layer.
    function automatic logic [511:0] next_mask(input logic [511:0] m, input int rows_in);
        logic [511:0] o;
        int           ng;
        int           n;
        bit           cin;
        o  = '0;
        ng = rows_in / 3;
        for (int g = 0; g < ng; g++) begin
            for (int c = 0; c < 32; c++) begin
                n   = col_count(m, g, c);
                cin = carry_in(m, g, c);
                o[(2 * g) * 32 + c]     = (n >= 1);
                o[(2 * g + 1) * 32 + c] = cin || ((n == 2) && !cin);
            end
        end
        for (int r = 3 * ng; r < rows_in; r++) begin
            o[(2 * ng + r - 3 * ng) * 32 +: 32] = m[r * 32 +: 32];
        end
        return o;
    endfunction

endpackage

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b;
    assign cout = a & b;
endmodule

// One carry-save layer: each group of three rows becomes a sum row and a
// carry row; leftover rows pass straight through.
module wallace_layer #(
    parameter int           ROWS_IN  = 3,
    parameter int           ROWS_OUT = 2 * (ROWS_IN / 3) + (ROWS_IN % 3),
    parameter logic [511:0] MASK_IN  = '0
) (
    input  logic [ROWS_IN*32-1:0]  rows_in,
    output wire  [ROWS_OUT*32-1:0] rows_out
);
    import wallace_tree_pkg::*;

    localparam int NG = ROWS_IN / 3;

    // Positions outside the live-bit map are constant zero by construction.
    wire unused_bits_s;
    assign unused_bits_s = ^(rows_in & ~MASK_IN[ROWS_IN*32-1:0]);

    for (genvar g = 0; g < NG; g++) begin : g_grp
        wire [31:0] s_row_s;
        wire [31:0] c_row_s;

        for (genvar c = 0; c < 32; c++) begin : g_col
            localparam int N   = col_count(MASK_IN, g, c);
            localparam bit CIN = carry_in(MASK_IN, g, c);
            localparam int P0  = pick(MASK_IN, g, c, 0);
            localparam int P1  = pick(MASK_IN, g, c, 1);
            localparam int P2  = pick(MASK_IN, g, c, 2);

            if (N == 3) begin : g_fa
                wire cy_s;
                full_adder u_fa (
                    .a    (rows_in[(3 * g + P0) * 32 + c]),
                    .b    (rows_in[(3 * g + P1) * 32 + c]),
                    .cin  (rows_in[(3 * g + P2) * 32 + c]),
                    .sum  (s_row_s[c]),
                    .cout (cy_s)
                );
                if (c < 31) begin : g_fwd
                    assign c_row_s[c + 1] = cy_s;
                end else begin : g_drop
                    wire cy_unused_s;
                    assign cy_unused_s = cy_s;
                end
            end else if ((N == 2) && CIN) begin : g_ha
                wire cy_s;
                half_adder u_ha (
                    .a    (rows_in[(3 * g + P0) * 32 + c]),
                    .b    (rows_in[(3 * g + P1) * 32 + c]),
                    .sum  (s_row_s[c]),
                    .cout (cy_s)
                );
                if (c < 31) begin : g_fwd
                    assign c_row_s[c + 1] = cy_s;
                end else begin : g_drop
                    wire cy_unused_s;
                    assign cy_unused_s = cy_s;
                end
            end else if (N == 2) begin : g_pass2
                // Carry slot is free, so the second bit simply drops into it.
                assign s_row_s[c] = rows_in[(3 * g + P0) * 32 + c];
                assign c_row_s[c] = rows_in[(3 * g + P1) * 32 + c];
            end else if (N == 1) begin : g_pass1
                assign s_row_s[c] = rows_in[(3 * g + P0) * 32 + c];
            end else begin : g_empty
                assign s_row_s[c] = 1'b0;
            end

            if (!CIN && (N != 2)) begin : g_cz
                assign c_row_s[c] = 1'b0;
            end
        end

        assign rows_out[(2 * g) * 32 +: 32]     = s_row_s;
        assign rows_out[(2 * g + 1) * 32 +: 32] = c_row_s;
    end

    for (genvar r = 3 * NG; r < ROWS_IN; r++) begin : g_left
        assign rows_out[(2 * NG + r - 3 * NG) * 32 +: 32] = rows_in[r * 32 +: 32];
    end
endmodule

module wallace_tree (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] MUR,
    input  logic [15:0] MUD,
    output logic [31:0] result
);
    import wallace_tree_pkg::*;

    localparam logic [511:0] M0 = pp_mask();
    localparam logic [511:0] M1 = next_mask(M0, 16);
    localparam logic [511:0] M2 = next_mask(M1, 11);
    localparam logic [511:0] M3 = next_mask(M2, 8);
    localparam logic [511:0] M4 = next_mask(M3, 6);
    localparam logic [511:0] M5 = next_mask(M4, 4);

    wire  [16*32-1:0] pp_s;
    wire  [11*32-1:0] l1_s;
    wire  [8*32-1:0]  l2_s;
    wire  [6*32-1:0]  l3_s;
    wire  [4*32-1:0]  l4_s;
    wire  [3*32-1:0]  l5_s;
    wire  [2*32-1:0]  l6_s;
    wire  [32:0]      carry_s;
    wire  [31:0]      final_sum_s;
    wire              carry_unused_s;
    logic [31:0]      result_r;

    for (genvar i = 0; i < 16; i++) begin : g_pp
        assign pp_s[i * 32 +: 32] = 32'({16{MUR[i]}} & MUD) << i;
    end

    wallace_layer #(.ROWS_IN(16), .MASK_IN(M0)) u_l1 (.rows_in(pp_s), .rows_out(l1_s));
    wallace_layer #(.ROWS_IN(11), .MASK_IN(M1)) u_l2 (.rows_in(l1_s), .rows_out(l2_s));
    wallace_layer #(.ROWS_IN(8),  .MASK_IN(M2)) u_l3 (.rows_in(l2_s), .rows_out(l3_s));
    wallace_layer #(.ROWS_IN(6),  .MASK_IN(M3)) u_l4 (.rows_in(l3_s), .rows_out(l4_s));
    wallace_layer #(.ROWS_IN(4),  .MASK_IN(M4)) u_l5 (.rows_in(l4_s), .rows_out(l5_s));
    wallace_layer #(.ROWS_IN(3),  .MASK_IN(M5)) u_l6 (.rows_in(l5_s), .rows_out(l6_s));

    // Ripple carry-propagate adder; the carry out of bit 31 is always zero.
    assign carry_s[0] = 1'b0;
    for (genvar k = 0; k < 32; k++) begin : g_cpa
        full_adder u_fa (
            .a    (l6_s[k]),
            .b    (l6_s[32 + k]),
            .cin  (carry_s[k]),
            .sum  (final_sum_s[k]),
            .cout (carry_s[k + 1])
        );
    end
    assign carry_unused_s = carry_s[32];

    // Product register, cleared asynchronously by Reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            result_r <= 32'h0000_0000;
        end else begin
            result_r <= final_sum_s;
        end
    end

    assign result = result_r;
endmodule

// File: tb/tb_wallace_tree.sv
// Directed, exhaustive-low-range and random checks of wallace_tree against
// hand-computed products and the behavioural multiply.
module tb_wallace_tree;

    logic        Clk;
    logic        Reset;
    logic [15:0] MUR;
    logic [15:0] MUD;
    logic [31:0] result;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] mur;
        logic [15:0] mud;
        logic [31:0] prod;
    } vec_t;

    vec_t vecs [12];

    wallace_tree dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .MUR    (MUR),
        .MUD    (MUD),
        .result (result)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: result=%h expected=%h (MUR=%h MUD=%h)", name, act, exp, MUR, MUD);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] wa;
        logic [31:0] wb;
        wa = {16'h0000, a};
        wb = {16'h0000, b};
        return wa * wb;
    endfunction

    initial begin
        vecs[0]  = '{16'h0000, 16'h1234, 32'h0000_0000};
        vecs[1]  = '{16'h0001, 16'hABCD, 32'h0000_ABCD};
        vecs[2]  = '{16'h8000, 16'h0002, 32'h0001_0000};
        vecs[3]  = '{16'hB333, 16'h0030, 32'h0021_9990};
        vecs[4]  = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
        vecs[5]  = '{16'hFFFF, 16'h8001, 32'h8000_7FFF};
        vecs[6]  = '{16'hFFFF, 16'h00FF, 32'h00FE_FF01};
        vecs[7]  = '{16'hFFFF, 16'h0001, 32'h0000_FFFF};
        vecs[8]  = '{16'h1234, 16'h5678, 32'h0626_0060};
        vecs[9]  = '{16'hAAAA, 16'h5555, 32'h38E3_1C72};
        vecs[10] = '{16'h0100, 16'h0100, 32'h0001_0000};
        vecs[11] = '{16'hFFFF, 16'h0000, 32'h0000_0000};

        // Reset held across edges, then released with all-ones operands.
        Reset = 1'b1;
        MUR   = 16'hFFFF;
        MUD   = 16'hFFFF;
        #1;
        check("reset_initial", result, 32'h0000_0000);
        repeat (2) @(posedge Clk);
        #1;
        check("reset_hold", result, 32'h0000_0000);
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        check("reset_release", result, 32'hFFFE_0001);

        // Asynchronous clear between edges, then held through an edge.
        Reset = 1'b1;
        #1;
        check("async_reset", result, 32'h0000_0000);
        @(posedge Clk);
        #1;
        check("reset_through_edge", result, 32'h0000_0000);
        Reset = 1'b0;

        // Directed table, applied back to back.
        for (int i = 0; i < 12; i++) begin
            MUR = vecs[i].mur;
            MUD = vecs[i].mud;
            @(posedge Clk);
            #1;
            check($sformatf("vec%0d", i), result, vecs[i].prod);
        end

        // Operand changes between edges must not reach the output.
        MUR = 16'h1234;
        MUD = 16'h5678;
        @(posedge Clk);
        #1;
        MUR = 16'hFFFF;
        MUD = 16'hFFFF;
        #2;
        check("hold_between_edges", result, 32'h0626_0060);
        @(posedge Clk);
        #1;
        check("next_edge_update", result, 32'hFFFE_0001);

        // Exhaustive low range, one pair per cycle.
        for (int a = 0; a < 128; a++) begin
            for (int b = 0; b < 128; b++) begin
                MUR = 16'(a);
                MUD = 16'(b);
                @(posedge Clk);
                #1;
                check("exhaustive", result, ref_mul(16'(a), 16'(b)));
            end
        end

        // Random pairs with a reset pulse in the middle.
        for (int i = 0; i < 20000; i++) begin
            if (i == 10000) begin
                Reset = 1'b1;
                #1;
                check("rand_async_reset", result, 32'h0000_0000);
                @(posedge Clk);
                #1;
                check("rand_after_reset", result, 32'h0000_0000);
                Reset = 1'b0;
            end
            MUR = 16'($urandom);
            MUD = 16'($urandom);
            @(posedge Clk);
            #1;
            check("random", result, ref_mul(MUR, MUD));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
